// File: rtl/stopwatch_lap_pkg.sv
// Shared types and helpers for the BCD lap stopwatch.
// Holds the state enum, digit width and segment decode.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } sw_state_t;

  localparam int BCD_W = 4;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_lap_if.sv
// Button, preload and display signals of the stopwatch.
// The stopwatch core is the slave; the board side is the master.
interface stopwatch_lap_if #(
  parameter int NUM_DIGITS = 4
);
  import stopwatch_pkg::*;

  localparam int W = BCD_W * NUM_DIGITS;

  logic                  start;
  logic                  lap;
  logic                  count_down;
  logic                  load;
  logic [W-1:0]          load_value;
  logic [W-1:0]          HEX_display_digits;
  logic [BCD_W-1:0]      LED_binary_coded_decimal;
  logic [NUM_DIGITS-1:0] anode_bits;
  logic [6:0]            seven_segments_LED_output;
  logic                  running;
  logic                  lap_active;
  logic                  expired;

  modport master (
    output start,
    output lap,
    output count_down,
    output load,
    output load_value,
    input  HEX_display_digits,
    input  LED_binary_coded_decimal,
    input  anode_bits,
    input  seven_segments_LED_output,
    input  running,
    input  lap_active,
    input  expired
  );

  modport slave (
    input  start,
    input  lap,
    input  count_down,
    input  load,
    input  load_value,
    output HEX_display_digits,
    output LED_binary_coded_decimal,
    output anode_bits,
    output seven_segments_LED_output,
    output running,
    output lap_active,
    output expired
  );

endinterface

// File: rtl/stopwatch_lap_scan.sv
// Multiplexed seven-segment scanner for the stopwatch display.
// Cycles one-cold anodes across the digits, LSD first.
module seven_seg_scan
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BCD_W*NUM_DIGITS-1:0] value,
  output logic [BCD_W-1:0]            bcd,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic [6:0]                  seg
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [RW-1:0] RMAX =
    RW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] IMAX =
    IW'(NUM_DIGITS - 1);

  logic [RW-1:0] refresh;
  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh <= '0;
      idx     <= '0;
    end else if (refresh == RMAX) begin
      refresh <= '0;
      idx     <= (idx == IMAX) ? '0 : idx + IW'(1);
    end else begin
      refresh <= refresh + RW'(1);
    end
  end

  assign bcd   = value[idx*BCD_W +: BCD_W];
  assign anode = ~(NUM_DIGITS'(1) << idx);
  assign seg   = bcd_to_seg(bcd);

endmodule

// File: rtl/stopwatch_lap.sv
// BCD up/down stopwatch with lap freeze and expiry.
// Drives a multiplexed active-low seven-segment display.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 100000,
  parameter int REFRESH_CYCLES = 1000
) (
  input logic           clk,
  input logic           reset,
  stopwatch_lap_if.slave bus
);

  localparam int W  = BCD_W * NUM_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX =
    TW'(TICK_DIV - 1);

  function automatic logic [W-1:0] bcd_inc(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[i*BCD_W +: BCD_W] == 4'd9) begin
          r[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          r[i*BCD_W +: BCD_W] =
            v[i*BCD_W +: BCD_W] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[i*BCD_W +: BCD_W] == 4'd0) begin
          r[i*BCD_W +: BCD_W] = 4'd9;
        end else begin
          r[i*BCD_W +: BCD_W] =
            v[i*BCD_W +: BCD_W] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_clamp(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*BCD_W +: BCD_W] > 4'd9)
        r[i*BCD_W +: BCD_W] = 4'd9;
    end
    return r;
  endfunction

  sw_state_t     state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [W-1:0]  count, count_nx;
  logic [W-1:0]  lap_val, lap_nx;
  logic [W-1:0]  count_dn, display;
  logic          lap_on, lap_on_nx;
  logic          mode, mode_nx;
  logic          start_s, start_p;
  logic          lap_s, lap_p;
  logic          start_e, lap_e;
  logic          step, zero_hit, lap_ok;

  assign start_e  = start_s & ~start_p;
  assign lap_e    = lap_s & ~lap_p;
  assign step     = (state == S_RUN) &&
                    (tick == TICK_MAX);
  assign count_dn = bcd_dec(count);
  assign zero_hit = step && mode &&
                    (count != '0) &&
                    (count_dn == '0);
  assign lap_ok   = (state == S_RUN) ||
                    (state == S_PAUSED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tick    <= '0;
      count   <= '0;
      lap_val <= '0;
      lap_on  <= 1'b0;
      mode    <= 1'b0;
      start_s <= 1'b0;
      start_p <= 1'b0;
      lap_s   <= 1'b0;
      lap_p   <= 1'b0;
    end else begin
      state   <= state_nx;
      tick    <= tick_nx;
      count   <= count_nx;
      lap_val <= lap_nx;
      lap_on  <= lap_on_nx;
      mode    <= mode_nx;
      start_s <= bus.start;
      start_p <= start_s;
      lap_s   <= bus.lap;
      lap_p   <= lap_s;
    end
  end

  always_comb begin
    state_nx  = state;
    tick_nx   = tick;
    count_nx  = count;
    lap_nx    = lap_val;
    lap_on_nx = lap_on;
    mode_nx   = mode;
    if (bus.load) begin
      state_nx  = S_IDLE;
      tick_nx   = '0;
      count_nx  = bcd_clamp(bus.load_value);
      lap_nx    = '0;
      lap_on_nx = 1'b0;
    end else begin
      if (state == S_IDLE)
        mode_nx = bus.count_down;
      // Lap sees the count from before any step on this edge.
      if (lap_e && lap_ok) begin
        if (lap_on) begin
          lap_on_nx = 1'b0;
        end else begin
          lap_on_nx = 1'b1;
          lap_nx    = count;
        end
      end
      unique case (state)
        S_IDLE: begin
          if (start_e)
            state_nx = (bus.count_down &&
                        count == '0) ?
                       S_DONE : S_RUN;
        end
        S_RUN: begin
          tick_nx = step ? '0 : tick + TW'(1);
          if (step) begin
            if (!mode)
              count_nx = bcd_inc(count);
            else if (count != '0)
              count_nx = count_dn;
          end
          if (zero_hit)
            state_nx = S_DONE;
          else if (start_e)
            state_nx = S_PAUSED;
        end
        S_PAUSED: begin
          if (start_e)
            state_nx = S_RUN;
        end
        S_DONE: begin
          if (start_e)
            state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
      if (state_nx == S_IDLE ||
          state_nx == S_DONE)
        tick_nx = '0;
    end
  end

  assign display                = lap_on ? lap_val : count;
  assign bus.HEX_display_digits = display;
  assign bus.running            = (state == S_RUN);
  assign bus.expired            = (state == S_DONE);
  assign bus.lap_active         = lap_on;

  seven_seg_scan #(
    .NUM_DIGITS     (NUM_DIGITS),
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .value (display),
    .bcd   (bus.LED_binary_coded_decimal),
    .anode (bus.anode_bits),
    .seg   (bus.seven_segments_LED_output)
  );

endmodule

// File: tb/tb_stopwatch_lap.sv
// Randomized bench for stopwatch_lap against a decimal model.
// Directed scenarios first, then random button traffic.
module tb_stopwatch_lap;

  localparam int ND   = 4;
  localparam int TD   = 2;
  localparam int RC   = 4;
  localparam int MAXV = 10000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  stopwatch_lap_if #(.NUM_DIGITS(ND)) bus();

  stopwatch_lap #(
    .NUM_DIGITS     (ND),
    .TICK_DIV       (TD),
    .REFRESH_CYCLES (RC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // 0 idle, 1 run, 2 paused, 3 done
  int m_st, m_cnt, m_tick, m_lapv, m_cyc;
  bit m_lapon, m_mode;
  bit s_now, s_old, l_now, l_old;

  logic [6:0] seg_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000
  };

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_val(
    input logic [15:0] v
  );
    int r;
    int n;
    r = 0;
    for (int i = 3; i >= 0; i--) begin
      n = int'(v[i*4 +: 4]);
      if (n > 9) n = 9;
      r = r * 10 + n;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(
    input int v
  );
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_edge();
    bit se, le, step;
    int nst;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_tick = 0;
      m_lapv = 0; m_lapon = 0; m_mode = 0;
      s_now = 0; s_old = 0;
      l_now = 0; l_old = 0;
      m_cyc = 0;
      return;
    end
    se = s_now && !s_old;
    le = l_now && !l_old;
    s_old = s_now; s_now = bus.start;
    l_old = l_now; l_now = bus.lap;
    m_cyc++;
    if (bus.load) begin
      m_cnt = clamp_val(bus.load_value);
      m_tick = 0; m_st = 0;
      m_lapon = 0; m_lapv = 0;
      return;
    end
    step = (m_st == 1) && (m_tick == TD - 1);
    if (le && (m_st == 1 || m_st == 2)) begin
      if (m_lapon) m_lapon = 0;
      else begin
        m_lapon = 1;
        m_lapv = m_cnt;
      end
    end
    if (m_st == 0) m_mode = bus.count_down;
    nst = m_st;
    if (se) begin
      case (m_st)
        0: nst = (bus.count_down && m_cnt == 0)
                 ? 3 : 1;
        1: nst = 2;
        2: nst = 1;
        default: nst = 0;
      endcase
    end
    if (m_st == 1) m_tick = (m_tick + 1) % TD;
    if (step) begin
      if (!m_mode) m_cnt = (m_cnt + 1) % MAXV;
      else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) nst = 3;
      end
    end
    if (nst == 0 || nst == 3) m_tick = 0;
    m_st = nst;
  endtask

  task automatic compare();
    logic [15:0] dbcd;
    logic [3:0]  dig;
    logic [3:0]  an;
    int idx;
    dbcd = to_bcd(m_lapon ? m_lapv : m_cnt);
    idx  = (m_cyc / RC) % ND;
    dig  = dbcd[idx*4 +: 4];
    an   = ~(4'd1 << idx);
    check("disp", 32'(bus.HEX_display_digits),
          32'(dbcd));
    check("running", 32'(bus.running),
          32'(m_st == 1));
    check("lap_active", 32'(bus.lap_active),
          32'(m_lapon));
    check("expired", 32'(bus.expired),
          32'(m_st == 3));
    check("bcd", 32'(bus.LED_binary_coded_decimal),
          32'(dig));
    check("anode", 32'(bus.anode_bits), 32'(an));
    check("seg", 32'(bus.seven_segments_LED_output),
          32'(seg_tab[dig]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    run(2);
    bus.start = 1'b0;
    tick();
  endtask

  task automatic press_lap();
    bus.lap = 1'b1;
    run(2);
    bus.lap = 1'b0;
    tick();
  endtask

  task automatic do_load(
    input logic [15:0] v,
    input logic        cd
  );
    bus.load       = 1'b1;
    bus.load_value = v;
    bus.count_down = cd;
    tick();
    bus.load = 1'b0;
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.lap        = 1'b0;
    bus.count_down = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    run(2);
    reset = 1'b0;
    run(10);
    press_start();
    run(20);
    press_start();
    run(50);
    press_start();
    run(10);
    press_lap();
    run(30);
    press_lap();
    run(5);
    do_load(16'h9999, 1'b0);
    press_start();
    run(6);
    do_load(16'h0003, 1'b1);
    press_start();
    run(12);
    press_start();
    press_lap();
    run(4);
    do_load(16'h0000, 1'b0);
    press_start();
    run(7);
    bus.start = 1'b1;
    bus.lap   = 1'b1;
    run(2);
    bus.start = 1'b0;
    bus.lap   = 1'b0;
    run(4);
    press_start();
    run(5);
    do_load(16'h1234, 1'b0);
    run(3);
    do_load(16'h0C05, 1'b0);
    run(2);
    press_start();
    press_lap();
    run(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 8 == 0)
        bus.start = ~bus.start;
      if ($urandom % 10 == 0)
        bus.lap = ~bus.lap;
      if ($urandom % 25 == 0)
        bus.count_down = 1'($urandom);
      bus.load = ($urandom % 60 == 0);
      if ($urandom % 2 == 0)
        bus.load_value = 16'($urandom_range(0, 5));
      else
        bus.load_value = 16'($urandom);
      reset = ($urandom % 500 == 0);
      tick();
    end
    reset    = 1'b0;
    bus.load = 1'b0;
    run(4);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
# stopwatch_lap

Parametrised BCD stopwatch: a start/stop toggle, a lap (split) freeze, count-up or count-down mode with preload, and expiry detection. It drives the board's multiplexed active-low seven-segment display. It replaces the fixed 4-digit count-up stopwatch and sits between the debounced push-button inputs and the display pins, all on the single system clock.

## Interface
- NUM_DIGITS, 4: number of BCD digits (2..8).
- TICK_DIV, 100000: clk cycles per count step (≥2).
- REFRESH_CYCLES, 1000: clk cycles each digit stays lit during the display scan (≥2).
- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start/stop button (level); each rising edge toggles run/pause.
- lap  in  1  lap button (level); each rising edge toggles the lap freeze.
- count_down  in  1  mode select: 1 = count down, 0 = count up. Sampled only in IDLE.
- load  in  1  level-sensitive. While high: count = load_value, tick counter = 0, state = IDLE, lap is cleared.
- load_value  in  4*NUM_DIGITS  BCD preload value. Any nibble greater than 9 is clamped to 9.
- HEX_display_digits  out  4*NUM_DIGITS  currently displayed BCD value (lap value while lap_active, else the live count).
- LED_binary_coded_decimal  out  4  BCD nibble of the digit currently being scanned.
- anode_bits  out  NUM_DIGITS  one-cold digit enable.
- seven_segments_LED_output  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- running  out  1  high in RUN.
- lap_active  out  1  high while the display is frozen on a lap value.
- expired  out  1  high in DONE.

## Operation
- Edge detection: start and lap are registered once; a rising edge is detected when the current sample is 1 and the previous sample is 0.
- State machine: IDLE, RUN, PAUSED, DONE. Transitions:
  - IDLE --start edge--> RUN. In count-down mode, if the count is 0, go to DONE instead.
  - RUN --start edge--> PAUSED.
  - PAUSED --start edge--> RUN.
  - DONE --start edge--> IDLE. The count is held.
  - Any state --load--> IDLE.
- Mode: count_down is latched into the mode register while in IDLE and held constant in every other state.
- Tick counter:
  - Runs 0..TICK_DIV-1 only in RUN; holds its value in PAUSED.
  - Cleared by reset, load, and entry to IDLE or DONE.
  - Each count step happens on the clock edge where the tick counter equals TICK_DIV-1.
- Count up: BCD ripple carry. The maximum value (all 9s) wraps to 0 and the stopwatch keeps running.
- Count down: BCD ripple borrow. The step that reaches 0 also moves the state to DONE, on the same edge. The count holds at 0.
- Lap:
  - A lap edge while not lap_active, in RUN or PAUSED, captures the count into the lap register and sets lap_active.
  - A lap edge while lap_active clears it.
  - The live count keeps running underneath the frozen display.
  - Lap edges in IDLE or DONE are ignored.
- Display scan:
  - A scan index 0..NUM_DIGITS-1 advances every REFRESH_CYCLES clocks and wraps back to 0.
  - anode_bits = ~(1 << index); digit 0 is the least-significant digit.
  - LED_binary_coded_decimal = the nibble of HEX_display_digits at the scan index. Segment patterns follow.
- Segment patterns (active-low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- Reset values:
  - State IDLE; count, lap register, tick counter, scan index and refresh counter all 0.
  - running, lap_active and expired are 0; HEX_display_digits is 0.
  - anode_bits = all ones except bit 0 = 0.
  - LED_binary_coded_decimal = 0; seven_segments_LED_output = 1000000.
- Reset and load take effect on the next edge and override every other input.
- Button latency:
  - A button first sampled high at edge k is detected as a rising edge at edge k+1.
  - The state, running and lap_active change at edge k+1.
- Counting and display latency:
  - Count and HEX_display_digits update on the same edge (registered).
  - The segments follow the scanned nibble combinationally within that cycle.
- Simultaneous events on the same edge:
  - start and lap together: lap captures the pre-toggle count, then start toggles the state.
  - A count step and a lap capture together: lap captures the value before the step.
  - A count-down step to 0 together with a start edge: DONE wins; the start edge is dropped.
- Reset in mid-count or mid-lap returns to the reset values; no partial state survives.

## Structure
- Package stopwatch_pkg holds:
  - the state enum type sw_state_t;
  - the digit width constant BCD_W = 4;
  - function bcd_to_seg(logic [3:0]) returning the active-low patterns above, with 1111111 for 10-15.
- Sub-module seven_seg_scan(NUM_DIGITS, REFRESH_CYCLES) contains the refresh counter, the scan index, the anode decode and bcd_to_seg.
- The top module contains edge detection, the state machine, the tick counter, the BCD up/down counter and the lap register.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=2, REFRESH_CYCLES=4.
- Reset then idle: all outputs hold the reset values; after 4 clocks anode_bits=1101, and the segments stay 1000000.
- Count up: press start. running rises 2 edges after the press. The display reads 0001 after the first tick (2 clocks later), then 0009, then 0010. Preloading 9999 and running one tick gives 0000.
- Pause/resume: press start at count 0042 → the count holds 0042 for 50 clocks. Press start again → it resumes at 0043 after the next tick.
- Lap: press lap at 0017 → the display holds 0017 while the live count reaches 0030. Press lap again → the display shows the live count.
- Count down: load 0003 with count_down=1, press start. The sequence is 0002, 0001, 0000; expired=1 on the 0000 edge and the count holds. start → IDLE; a lap press is ignored.
- Simultaneous events:
  - start and lap on the same edge: lap captures the pre-toggle value.
  - load asserted during RUN: the next edge gives IDLE with count = load_value.
  - load_value nibble 0xC: loads as 9.
